// File: rtl/m68k_iack_sequencer.sv
`default_nettype none
// ==========================================================================
// m68k_iack_sequencer - IPL filter/qualifier and 68k interrupt-acknowledge
// cycle sequencer (int_ack strobe, vector capture, spurious timeout).
// Revision: 1.0
// ==========================================================================
module m68k_iack_sequencer #(
  parameter int ACK_TIMEOUT     = 16,
  parameter int SPURIOUS_VECTOR = 24
) (
  input  logic       wb_clk_i,
  input  logic       wb_reset_i,
  input  logic [2:0] ipl_i,
  output logic       int_ack_o,
  input  logic       wb_ack_i,
  input  logic [7:0] wb_dat_i,
  input  logic [2:0] cpu_mask_i,
  input  logic       iack_req_i,
  output logic       irq_pending_o,
  output logic [2:0] irq_level_o,
  output logic       vec_valid_o,
  output logic [7:0] vec_o,
  output logic       vec_spurious_o,
  output logic       busy_o
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_PEND = 3'd1;
  localparam logic [2:0] c_ACK  = 3'd2;
  localparam logic [2:0] c_DONE = 3'd3;
  localparam logic [2:0] c_HOLD = 3'd4;

  localparam logic [7:0] c_TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] c_SPURIOUS     = 8'(SPURIOUS_VECTOR);

  logic [2:0] r_state;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic       r_real1;
  logic       r_real2;
  logic       r_nmi_armed;
  logic [7:0] r_cnt;
  logic       r_hold_cnt;
  logic       r_int_ack;
  logic       r_pending;
  logic [2:0] r_level;
  logic       r_vec_valid;
  logic [7:0] r_vec;
  logic       r_spurious;

  logic [2:0] w_lvl;
  logic       w_stable;
  logic       w_qualify;
  logic       w_higher;

  // Zeros forced during HOLD are not real samples; they must neither look
  // stable nor re-arm the level-7 edge detector.
  assign w_lvl     = r_s2;
  assign w_stable  = r_real1 && r_real2 && (r_s1 == r_s2);
  assign w_qualify = w_stable && (w_lvl != 3'd0) &&
                     ((w_lvl > cpu_mask_i) || ((w_lvl == 3'd7) && r_nmi_armed));
  assign w_higher  = w_qualify && (w_lvl > r_level);

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      r_state     <= c_IDLE;
      r_s1        <= 3'd0;
      r_s2        <= 3'd0;
      r_real1     <= 1'b0;
      r_real2     <= 1'b0;
      r_nmi_armed <= 1'b1;
      r_cnt       <= 8'd0;
      r_hold_cnt  <= 1'b0;
      r_int_ack   <= 1'b0;
      r_pending   <= 1'b0;
      r_level     <= 3'd0;
      r_vec_valid <= 1'b0;
      r_vec       <= 8'd0;
      r_spurious  <= 1'b0;
    end else begin
      r_vec_valid <= 1'b0;

      if (r_state == c_HOLD) begin
        r_s1    <= 3'd0;
        r_s2    <= 3'd0;
        r_real1 <= 1'b0;
        r_real2 <= 1'b0;
      end else begin
        r_s1    <= ipl_i;
        r_s2    <= r_s1;
        r_real1 <= 1'b1;
        r_real2 <= r_real1;
      end

      if (w_stable && (w_lvl != 3'd7)) begin
        r_nmi_armed <= 1'b1;
      end

      case (r_state)
        c_IDLE: begin
          if (w_qualify) begin
            r_state   <= c_PEND;
            r_pending <= 1'b1;
            r_level   <= w_lvl;
          end
        end
        c_PEND: begin
          if (iack_req_i) begin
            r_state   <= c_ACK;
            r_pending <= 1'b0;
            r_int_ack <= 1'b1;
            r_cnt     <= 8'd0;
            // Later assignment overrides any same-cycle re-arm above.
            if (r_level == 3'd7) begin
              r_nmi_armed <= 1'b0;
            end
          end else if (w_stable && !w_qualify) begin
            r_state   <= c_IDLE;
            r_pending <= 1'b0;
            r_level   <= 3'd0;
          end else if (w_higher) begin
            r_level <= w_lvl;
          end
        end
        c_ACK: begin
          r_cnt <= r_cnt + 8'd1;
          if (wb_ack_i) begin
            r_vec      <= wb_dat_i;
            r_spurious <= 1'b0;
            r_int_ack  <= 1'b0;
            r_state    <= c_DONE;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            r_vec      <= c_SPURIOUS;
            r_spurious <= 1'b1;
            r_int_ack  <= 1'b0;
            r_state    <= c_DONE;
          end
        end
        c_DONE: begin
          r_vec_valid <= 1'b1;
          r_hold_cnt  <= 1'b0;
          r_state     <= c_HOLD;
        end
        c_HOLD: begin
          if (r_hold_cnt) begin
            r_state <= c_IDLE;
            r_level <= 3'd0;
          end else begin
            r_hold_cnt <= 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign int_ack_o      = r_int_ack;
  assign irq_pending_o  = r_pending;
  assign irq_level_o    = r_level;
  assign vec_valid_o    = r_vec_valid;
  assign vec_o          = r_vec;
  assign vec_spurious_o = r_spurious;
  assign busy_o         = (r_state == c_ACK) || (r_state == c_DONE) || (r_state == c_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_m68k_iack_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_m68k_iack_sequencer - directed self-checking bench for the IACK sequencer.
// Revision: 1.0
// ==========================================================================
module tb_m68k_iack_sequencer;

  logic       wb_clk_i = 1'b0;
  logic       wb_reset_i;
  logic [2:0] ipl_i;
  logic       int_ack_o;
  logic       wb_ack_i;
  logic [7:0] wb_dat_i;
  logic [2:0] cpu_mask_i;
  logic       iack_req_i;
  logic       irq_pending_o;
  logic [2:0] irq_level_o;
  logic       vec_valid_o;
  logic [7:0] vec_o;
  logic       vec_spurious_o;
  logic       busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  m68k_iack_sequencer #(
    .ACK_TIMEOUT     (16),
    .SPURIOUS_VECTOR (24)
  ) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_reset_i     (wb_reset_i),
    .ipl_i          (ipl_i),
    .int_ack_o      (int_ack_o),
    .wb_ack_i       (wb_ack_i),
    .wb_dat_i       (wb_dat_i),
    .cpu_mask_i     (cpu_mask_i),
    .iack_req_i     (iack_req_i),
    .irq_pending_o  (irq_pending_o),
    .irq_level_o    (irq_level_o),
    .vec_valid_o    (vec_valid_o),
    .vec_o          (vec_o),
    .vec_spurious_o (vec_spurious_o),
    .busy_o         (busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_int_ack"}, int_ack_o, 1'b0);
    chk1({tag, "_pending"}, irq_pending_o, 1'b0);
    chk8({tag, "_level"}, {5'd0, irq_level_o}, 8'h00);
    chk1({tag, "_vec_valid"}, vec_valid_o, 1'b0);
    chk8({tag, "_vec"}, vec_o, 8'h00);
    chk1({tag, "_spurious"}, vec_spurious_o, 1'b0);
    chk1({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int cnt;

    wb_reset_i = 1'b1;
    ipl_i      = 3'd0;
    wb_ack_i   = 1'b0;
    wb_dat_i   = 8'h00;
    cpu_mask_i = 3'd0;
    iack_req_i = 1'b0;
    tick(2);
    chk_reset_outputs("reset");
    wb_reset_i = 1'b0;
    tick(3);

    // Normal acknowledge, vector returned one cycle after int_ack rises
    cpu_mask_i = 3'd2;
    ipl_i      = 3'd3;
    tick(1);
    chk1("t1_pend_e1", irq_pending_o, 1'b0);
    tick(1);
    chk1("t1_pend_e2", irq_pending_o, 1'b0);
    tick(1);
    chk1("t1_pend_e3", irq_pending_o, 1'b1);
    chk8("t1_level", {5'd0, irq_level_o}, 8'h03);
    iack_req_i = 1'b1;
    tick(1);
    iack_req_i = 1'b0;
    chk1("t1_int_ack_rise", int_ack_o, 1'b1);
    chk1("t1_pend_drop", irq_pending_o, 1'b0);
    chk1("t1_busy", busy_o, 1'b1);
    tick(1);
    chk1("t1_int_ack_c2", int_ack_o, 1'b1);
    wb_ack_i = 1'b1;
    wb_dat_i = 8'h1B;
    tick(1);
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    chk1("t1_int_ack_fall", int_ack_o, 1'b0);
    chk1("t1_valid_early", vec_valid_o, 1'b0);
    chk8("t1_vec_capt", vec_o, 8'h1B);
    ipl_i = 3'd0;
    tick(1);
    chk1("t1_valid", vec_valid_o, 1'b1);
    chk8("t1_vec", vec_o, 8'h1B);
    chk1("t1_spurious", vec_spurious_o, 1'b0);
    tick(1);
    chk1("t1_valid_once", vec_valid_o, 1'b0);
    chk1("t1_busy_hold", busy_o, 1'b1);
    tick(1);
    chk1("t1_busy_end", busy_o, 1'b0);
    tick(3);

    // Masked level, then mask lowered, then withdrawal before iack
    cpu_mask_i = 3'd3;
    ipl_i      = 3'd3;
    tick(4);
    chk1("t2_masked", irq_pending_o, 1'b0);
    cpu_mask_i = 3'd2;
    tick(1);
    chk1("t2_unmasked", irq_pending_o, 1'b1);
    chk8("t2_level", {5'd0, irq_level_o}, 8'h03);
    ipl_i = 3'd0;
    tick(2);
    chk1("t2_still_pend", irq_pending_o, 1'b1);
    tick(1);
    chk1("t2_withdrawn", irq_pending_o, 1'b0);
    tick(2);

    // Timeout to spurious vector; stray ack/data outside ACK ignored
    ipl_i = 3'd4;
    tick(3);
    chk1("t3_pend", irq_pending_o, 1'b1);
    chk8("t3_level", {5'd0, irq_level_o}, 8'h04);
    wb_ack_i = 1'b1;
    wb_dat_i = 8'hAA;
    tick(1);
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    chk1("t3_stray_ack_pend", irq_pending_o, 1'b1);
    chk8("t3_stray_ack_vec", vec_o, 8'h1B);
    iack_req_i = 1'b1;
    tick(1);
    iack_req_i = 1'b0;
    hi = 0;
    for (int i = 0; i < 40 && int_ack_o; i++) begin
      hi++;
      tick(1);
    end
    chk8("t3_ack_high_cycles", hi[7:0], 8'd16);
    chk8("t3_vec", vec_o, 8'h18);
    chk1("t3_spurious", vec_spurious_o, 1'b1);
    tick(1);
    chk1("t3_valid", vec_valid_o, 1'b1);
    ipl_i = 3'd0;
    tick(4);

    // Level 7 behaves as an edge-triggered NMI
    cpu_mask_i = 3'd7;
    ipl_i      = 3'd7;
    tick(3);
    chk1("t4_nmi_pend", irq_pending_o, 1'b1);
    chk8("t4_nmi_level", {5'd0, irq_level_o}, 8'h07);
    iack_req_i = 1'b1;
    tick(1);
    iack_req_i = 1'b0;
    chk1("t4_int_ack", int_ack_o, 1'b1);
    wb_ack_i = 1'b1;
    wb_dat_i = 8'h1F;
    tick(1);
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    chk1("t4_int_ack_1cyc", int_ack_o, 1'b0);
    tick(1);
    chk1("t4_valid", vec_valid_o, 1'b1);
    chk8("t4_vec", vec_o, 8'h1F);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (irq_pending_o) cnt++;
    end
    chk8("t4_no_repend", cnt[7:0], 8'd0);
    ipl_i = 3'd0;
    tick(3);
    ipl_i = 3'd7;
    tick(3);
    chk1("t4_rearm_pend", irq_pending_o, 1'b1);
    chk8("t4_rearm_level", {5'd0, irq_level_o}, 8'h07);
    ipl_i = 3'd0;
    tick(3);
    chk1("t4_nmi_withdrawn", irq_pending_o, 1'b0);

    // One-cycle glitch ignored; pending level upgrades before iack
    cpu_mask_i = 3'd0;
    ipl_i      = 3'd5;
    tick(1);
    ipl_i = 3'd0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (irq_pending_o) cnt++;
    end
    chk8("t5_glitch", cnt[7:0], 8'd0);
    ipl_i = 3'd2;
    tick(3);
    chk1("t5_pend", irq_pending_o, 1'b1);
    chk8("t5_level2", {5'd0, irq_level_o}, 8'h02);
    ipl_i = 3'd6;
    tick(2);
    chk8("t5_level_before", {5'd0, irq_level_o}, 8'h02);
    tick(1);
    chk8("t5_level_upgrade", {5'd0, irq_level_o}, 8'h06);
    chk1("t5_pend_kept", irq_pending_o, 1'b1);

    // Reset during the third ACK cycle
    iack_req_i = 1'b1;
    tick(1);
    iack_req_i = 1'b0;
    chk1("t6_int_ack", int_ack_o, 1'b1);
    tick(2);
    chk1("t6_int_ack_c3", int_ack_o, 1'b1);
    wb_reset_i = 1'b1;
    tick(1);
    wb_reset_i = 1'b0;
    ipl_i      = 3'd0;
    chk_reset_outputs("t6_rst");
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (vec_valid_o) cnt++;
    end
    chk8("t6_no_valid", cnt[7:0], 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m68k_iack_sequencer.md
Name: m68k_iack_sequencer

Overview:
CPU-side counterpart of the interrupt controller. It sits between the 68k core and the controller's ipl/int_ack/Wishbone read path. It filters the incoming 3-bit priority level, qualifies it against the CPU status-register mask (level 7 edge-triggered as NMI), and signals a pending request to the core. On the core's grant it runs the interrupt-acknowledge cycle: asserts int_ack, captures the vector byte on the Wishbone ack, and falls back to a spurious vector on timeout.

Parameters:
ACK_TIMEOUT, 16, cycles int_ack_o may stay high waiting for wb_ack_i (legal range 2..255).
SPURIOUS_VECTOR, 24, vector number returned on timeout.

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge.
wb_reset_i  in  1  synchronous reset, active-high.
ipl_i  in  3  priority level from interrupt controller; 0 = none.
int_ack_o  out  1  interrupt-acknowledge strobe to controller.
wb_ack_i  in  1  controller ack; wb_dat_i valid in the same cycle.
wb_dat_i  in  8  vector byte from controller.
cpu_mask_i  in  3  SR interrupt mask I2..I0.
iack_req_i  in  1  one-cycle pulse from core: begin acknowledge; honoured only in PEND.
irq_pending_o  out  1  qualified request to core.
irq_level_o  out  3  level being requested/acknowledged.
vec_valid_o  out  1  one-cycle pulse: vec_o/vec_spurious_o valid.
vec_o  out  8  captured vector number.
vec_spurious_o  out  1  vec_o is SPURIOUS_VECTOR due to timeout.
busy_o  out  1  high in ACK, DONE, HOLD.

Behaviour:
- Reset values: state=IDLE, s1=s2=0, nmi_armed=1, counter=0. All outputs 0: int_ack_o, irq_pending_o, irq_level_o, vec_valid_o, vec_o, vec_spurious_o, busy_o.
- Sync/filter: s1<=ipl_i; s2<=s1; stable=(s1==s2); lvl=s2. A value present before edge k is stable after edge k+1. A single-cycle glitch is never stable.
- qualify = stable && lvl!=0 && (lvl>cpu_mask_i || (lvl==7 && nmi_armed)).
- nmi_armed: set whenever stable && lvl<7; cleared on the PEND->ACK transition when irq_level_o==7.
- IDLE: qualify -> PEND at edge k+2, irq_level_o<=lvl. irq_pending_o is registered and high from the same edge.
- PEND: irq_pending_o=1.
  - Stable higher qualifying lvl -> irq_level_o updates; stay in PEND.
  - Stable lvl that no longer qualifies (0, or <=mask and not an armed NMI) -> IDLE, irq_pending_o=0.
  - iack_req_i -> ACK; int_ack_o=1 and counter=0 from that edge; irq_pending_o=0. iack_req_i wins over a same-cycle withdrawal.
- ACK: counter increments each cycle.
  - wb_ack_i -> vec_o<=wb_dat_i, vec_spurious_o<=0, int_ack_o<=0, -> DONE.
  - Else counter==ACK_TIMEOUT-1 -> vec_o<=SPURIOUS_VECTOR, vec_spurious_o<=1, int_ack_o<=0, -> DONE.
  - wb_ack_i on the timeout cycle counts as a normal ack.
  - int_ack_o high time: min(ack latency+1, ACK_TIMEOUT) cycles.
- DONE: vec_valid_o=1 for exactly this cycle -> HOLD. vec_o/vec_spurious_o hold until the next DONE.
- HOLD: 2 cycles. s1/s2 forced to 0 and no qualification, covering the controller clearing ipl one cycle after int_ack falls. Then -> IDLE.
- wb_dat_i is ignored outside ACK. wb_ack_i outside ACK is ignored.
- cpu_mask_i may change in any cycle; it is evaluated combinationally against lvl.
- Reset mid-ACK: int_ack_o=0 after that edge, no vec_valid_o pulse, nmi_armed=1.
- Latency: ipl_i change to irq_pending_o = 3 edges. iack_req_i to int_ack_o = 1 edge. wb_ack_i to vec_valid_o = 2 edges.

Test Plan:
- ipl_i=3, mask=2; core pulses iack_req_i; controller returns wb_ack_i with dat=0x1B one cycle after int_ack_o rises -> irq_pending_o 3 edges after ipl change, irq_level_o=3, int_ack_o high 2 cycles, vec_valid_o pulse with vec_o=0x1B, vec_spurious_o=0.
- ipl_i=3, mask=3 -> irq_pending_o stays 0; then mask=2 -> irq_pending_o=1 next edge; then ipl_i=0 before iack -> back to IDLE, irq_pending_o=0.
- ipl_i=4, iack_req_i, wb_ack_i never asserted -> int_ack_o high exactly 16 cycles, vec_o=0x18, vec_spurious_o=1.
- NMI: ipl_i=7, mask=7 -> pending, serviced. ipl_i held at 7 -> no new pending. ipl_i 0 for 3 cycles, then 7 -> pending again with level 7.
- Glitch/upgrade: ipl_i=5 for 1 cycle -> no pending. ipl_i=2 stable, mask=0 -> PEND level 2; ipl_i=6 stable -> irq_level_o=6 before iack.
- wb_reset_i pulsed in the 3rd ACK cycle -> int_ack_o=0 next edge, no vec_valid_o, all outputs at reset values.
